// File: rtl/can_rx.sv
// Bit-level CAN receiver: synchronises the bus line, hard-syncs on the
// start-of-frame edge, removes stuff bits and deserialises SOF + 8 data
// bits (MSB first) + 1 recessive stop bit. Delivers the byte with a
// one-cycle valid strobe and flags stuff and framing errors.
module can_rx #(
    parameter int BIT_CYCLES   = 16,
    parameter int SAMPLE_POINT = 10,
    parameter int IDLE_BITS    = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       can_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       stuff_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int CNT_W  = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IDLE_W = $clog2(IDLE_BITS + 1);

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_SOF,
        S_DATA,
        S_STUFF_LAST,
        S_STOP
    } state_t;

    logic              sync1_q, can_s_q, can_prev_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    state_t            state_q, state_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              run_val_q, run_val_d;
    logic [2:0]        run_len_q, run_len_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              stuff_err_q, stuff_err_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q, busy_d;

    logic              fall_edge;
    logic              sample;
    logic              is_stuff;
    logic [2:0]        run_len_inc;

    assign fall_edge   = can_prev_q & ~can_s_q;
    assign sample      = (cnt_q == CNT_W'(SAMPLE_POINT - 1));
    // Five equal bits in a row means the next sampled bit is a stuff bit.
    assign is_stuff    = (run_len_q == 3'd5);
    assign run_len_inc = (can_s_q == run_val_q) ? run_len_q + 3'd1 : 3'd1;

    // Next-state logic: bit timer, frame FSM, destuffing and output pulses.
    always_comb begin
        cnt_d       = (cnt_q == CNT_W'(BIT_CYCLES - 1)) ? '0 : cnt_q + CNT_W'(1);
        state_d     = state_q;
        idle_cnt_d  = idle_cnt_q;
        run_val_d   = run_val_q;
        run_len_d   = run_len_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        stuff_err_d = 1'b0;
        frame_err_d = 1'b0;
        // busy stays up through the rx_valid cycle and drops right after it.
        busy_d      = busy_q & ~rx_valid_q;

        case (state_q)
            S_WAIT_IDLE: begin
                if (sample) begin
                    if (can_s_q) begin
                        if (idle_cnt_q == IDLE_W'(IDLE_BITS - 1)) begin
                            idle_cnt_d = '0;
                            state_d    = S_IDLE;
                        end else begin
                            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                        end
                    end else begin
                        idle_cnt_d = '0;
                    end
                end
            end
            S_IDLE: begin
                if (fall_edge) begin
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_SOF;
                end
            end
            S_SOF: begin
                if (sample) begin
                    if (!can_s_q) begin
                        run_val_d = 1'b0;
                        run_len_d = 3'd1;
                        bit_idx_d = 3'd0;
                        state_d   = S_DATA;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA, S_STUFF_LAST: begin
                if (sample) begin
                    if (is_stuff) begin
                        if (can_s_q != run_val_q) begin
                            run_val_d = can_s_q;
                            run_len_d = 3'd1;
                            if (state_q == S_STUFF_LAST) begin
                                state_d = S_STOP;
                            end
                        end else begin
                            stuff_err_d = 1'b1;
                            busy_d      = 1'b0;
                            idle_cnt_d  = '0;
                            state_d     = S_WAIT_IDLE;
                        end
                    end else begin
                        shift_d   = {shift_q[6:0], can_s_q};
                        bit_idx_d = bit_idx_q + 3'd1;
                        run_val_d = can_s_q;
                        run_len_d = run_len_inc;
                        if (bit_idx_q == 3'd7) begin
                            state_d = (run_len_inc == 3'd5) ? S_STUFF_LAST : S_STOP;
                        end
                    end
                end
            end
            S_STOP: begin
                if (sample) begin
                    idle_cnt_d = '0;
                    state_d    = S_WAIT_IDLE;
                    if (can_s_q) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        busy_d      = 1'b0;
                    end
                end
            end
            default: begin
                idle_cnt_d = '0;
                busy_d     = 1'b0;
                state_d    = S_WAIT_IDLE;
            end
        endcase
    end

    // State registers; synchroniser idles recessive out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= 1'b1;
            can_s_q     <= 1'b1;
            can_prev_q  <= 1'b1;
            cnt_q       <= '0;
            state_q     <= S_WAIT_IDLE;
            idle_cnt_q  <= '0;
            run_val_q   <= 1'b0;
            run_len_q   <= 3'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            stuff_err_q <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sync1_q     <= can_in;
            can_s_q     <= sync1_q;
            can_prev_q  <= can_s_q;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            idle_cnt_q  <= idle_cnt_d;
            run_val_q   <= run_val_d;
            run_len_q   <= run_len_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            stuff_err_q <= stuff_err_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign stuff_err = stuff_err_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: doc/can_rx.md
Name: can_rx

Overview:
- Bit-level CAN receiver. It sits directly downstream of the transmit stage and consumes the serial bus line, either looped back from the transmitter or taken from the transceiver RX pin.
- It recovers bit timing from the start-of-frame edge, removes stuff bits and deserialises a simplified frame: SOF, 8 data bits MSB first, 1 recessive stop bit.
- It delivers the data byte with a one-cycle valid strobe, and flags stuff and framing errors.

Parameters:
- BIT_CYCLES, 16: clk cycles per nominal bit time (min 4).
- SAMPLE_POINT, 10: cycle index within a bit at which the line is sampled (range 2..BIT_CYCLES-1).
- IDLE_BITS, 3: consecutive recessive sampled bits required before a new SOF is accepted.

Ports:
- clk, input, 1: system clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- can_in, input, 1: serial bus line; 1 = recessive, 0 = dominant. Asynchronous to clk.
- rx_data, output, 8: last correctly received byte.
- rx_valid, output, 1: one-cycle pulse; rx_data is new this cycle.
- stuff_err, output, 1: one-cycle pulse on a bit-stuffing violation.
- frame_err, output, 1: one-cycle pulse when the stop bit is sampled dominant.
- busy, output, 1: high from SOF detection until the frame ends or aborts.

Behaviour:
- Reset: rx_data=8'h00, rx_valid=0, stuff_err=0, frame_err=0, busy=0. FSM goes to WAIT_IDLE; all counters are cleared; synchroniser flops are set to 1.
- Input path: 2-flop synchroniser gives can_s. All logic uses can_s; edge detect compares can_s with its registered copy.
- Bit timer:
  - cnt counts 0..BIT_CYCLES-1, then wraps to 0.
  - Sample strobe fires when cnt==SAMPLE_POINT-1.
  - Bit boundary occurs at wrap.
  - cnt is forced to 0 on the SOF edge (hard sync). There is no resynchronisation inside a frame.
- WAIT_IDLE:
  - Timer free-runs. Each sampled 1 increments idle_cnt; a sampled 0 clears it.
  - When idle_cnt reaches IDLE_BITS, go to IDLE.
- IDLE:
  - On a 1->0 edge of can_s: cnt=0, busy=1, go to SOF.
- SOF:
  - Sampled 0: stuff run = {value 0, length 1}, bit_idx=0, go to DATA.
  - Sampled 1 (glitch): busy=0, go to IDLE. No error pulse.
- Destuffing rule, applied from SOF through the last data bit:
  - Run length counts consecutive equal sampled bits, stuff bits included.
  - When the run reaches 5, the next sampled bit is a stuff bit.
  - If the stuff bit is the complement: discard it and set run = {its value, 1}.
  - If the stuff bit equals the run value: pulse stuff_err, busy=0, go to WAIT_IDLE. rx_data is unchanged.
- DATA:
  - Each non-stuff sample shifts into a shift register, MSB first, and increments bit_idx.
  - After the 8th data bit: if run==5, go to STUFF_LAST (one more stuff bit is expected, checked as above); otherwise go to STOP.
  - STUFF_LAST goes to STOP on a good stuff bit.
- STOP:
  - Sampled 1: rx_data<=shift register and rx_valid=1, both in the sample-strobe cycle. Then busy=0 and go to WAIT_IDLE.
  - Sampled 0: frame_err=1, busy=0, go to WAIT_IDLE. rx_data is unchanged.
- Latency: rx_valid is asserted 2 synchroniser cycles + SAMPLE_POINT cycles after the start of the stop bit on can_in.
- Error pulses and rx_valid are mutually exclusive and last exactly one cycle.
- reset_n asserted mid-frame: immediate return to reset values. After release, IDLE_BITS recessive bits are needed before the next frame is accepted.
- A line held dominant in WAIT_IDLE keeps idle_cnt at 0 indefinitely. This is not an error.

Test Plan (BIT_CYCLES=16, SAMPLE_POINT=10, IDLE_BITS=3):
- Clean frame: 3+ idle bits, then SOF, 0xA5 (10100101), stop=1 -> exactly one rx_valid pulse, rx_data=0xA5, no error pulses, busy falls the cycle after rx_valid.
- Stuffed frame: SOF, 0,0,0,0, stuff 1, 0,0,0,0, stop 1 (data 0x00) -> rx_valid, rx_data=0x00.
- Trailing stuff: data 0x1F (0,0,0,1,1,1,1,1), then stuff 0, then stop 1 -> rx_data=0x1F. Omitting the stuff bit (stop 1 directly) -> stuff_err pulse, no rx_valid, rx_data keeps its previous value.
- Stuff violation: SOF followed by 5 zeros with no stuff bit -> stuff_err pulse at the sample of the 6th dominant bit, busy=0. A following clean frame 0x3C after 3 idle bits -> rx_data=0x3C.
- Frame error: SOF, 0x81, stop=0 -> frame_err pulse, no rx_valid. Glitch: 4-cycle dominant pulse while in IDLE -> busy high for one bit time at most, then returns to 0 with no error pulses and no rx_valid.
- Reset mid-frame: assert reset_n low during data bit 4 of 0x55 -> all outputs reset at once. After release, a frame sent with only 2 idle bits is ignored; the same frame sent with 3 idle bits -> rx_data=0x55.
